// File: rtl/fbuf_pkg.sv
// ----------------------------------------------------------------------------
// fbuf_pkg
// Shared framebuffer definitions used by the fill arbiter and the AXI command
// handler: default frame geometry, BRAM address/pixel widths, and the fill
// engine state encoding.
// ----------------------------------------------------------------------------
package fbuf_pkg;

  localparam int FRAME_WIDTH_DEF     = 640;
  localparam int FRAME_HEIGHT_DEF    = 480;
  localparam int FBUF_ADDR_WIDTH_DEF = 19;
  localparam int FBUF_DATA_WIDTH_DEF = 8;
  localparam int COORD_WIDTH_DEF     = 12;

  // Fill engine states: IDLE waits for a command, SETUP computes the clipped
  // extents and start row base, FILL walks the rectangle in raster order.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/fbuf_rect_walker.sv
// ----------------------------------------------------------------------------
// fbuf_rect_walker
// Raster-order address generator for a rectangle fill. On setup it latches
// the start corner, clips the far edges to the frame and computes the start
// row base (the only multiply). While run is high and stall is low it emits
// one address per cycle and advances; a stalled cycle holds the position.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   setup         load counters from x/y/w/h (held in SETUP state)
//   run           walker active (FILL state)
//   stall         a pixel write owns the port this cycle
//   x, y, w, h    latched fill command
//   addr          BRAM address of the current position
//   valid         addr is issued as a write this cycle
//   last          current position is the final pixel of the rectangle
// ----------------------------------------------------------------------------
module fbuf_rect_walker
  import fbuf_pkg::*;
#(
  parameter int FRAME_WIDTH     = FRAME_WIDTH_DEF,
  parameter int FRAME_HEIGHT    = FRAME_HEIGHT_DEF,
  parameter int FBUF_ADDR_WIDTH = FBUF_ADDR_WIDTH_DEF,
  parameter int COORD_WIDTH     = COORD_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       setup,
  input  logic                       run,
  input  logic                       stall,
  input  logic [COORD_WIDTH-1:0]     x,
  input  logic [COORD_WIDTH-1:0]     y,
  input  logic [COORD_WIDTH-1:0]     w,
  input  logic [COORD_WIDTH-1:0]     h,
  output logic [FBUF_ADDR_WIDTH-1:0] addr,
  output logic                       valid,
  output logic                       last
);

  // One extra bit so x+w / y+h never wrap before clipping.
  localparam int CXW = COORD_WIDTH + 1;
  localparam logic [CXW-1:0]             FW_C   = CXW'(FRAME_WIDTH);
  localparam logic [CXW-1:0]             FH_C   = CXW'(FRAME_HEIGHT);
  localparam logic [CXW-1:0]             ONE    = CXW'(1);
  localparam logic [FBUF_ADDR_WIDTH-1:0] STRIDE = FBUF_ADDR_WIDTH'(FRAME_WIDTH);

  logic [CXW-1:0]             cx, cy;
  logic [CXW-1:0]             x_start, x_end, y_end;
  logic [FBUF_ADDR_WIDTH-1:0] row_base;
  logic [CXW-1:0]             x_sum, y_sum;
  logic                       row_last;

  assign x_sum = {1'b0, x} + {1'b0, w};
  assign y_sum = {1'b0, y} + {1'b0, h};

  assign valid    = run & ~stall;
  assign row_last = (cx + ONE) == x_end;
  assign last     = row_last && ((cy + ONE) == y_end);
  assign addr     = row_base + FBUF_ADDR_WIDTH'(cx);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx       <= '0;
      cy       <= '0;
      x_start  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      row_base <= '0;
    end else if (setup) begin
      cx       <= {1'b0, x};
      cy       <= {1'b0, y};
      x_start  <= {1'b0, x};
      x_end    <= (x_sum > FW_C) ? FW_C : x_sum;
      y_end    <= (y_sum > FH_C) ? FH_C : y_sum;
      row_base <= FBUF_ADDR_WIDTH'(y) * STRIDE;
    end else if (valid) begin
      if (row_last) begin
        cx       <= x_start;
        cy       <= cy + ONE;
        row_base <= row_base + STRIDE;
      end else begin
        cx <= cx + ONE;
      end
    end
  end

endmodule

// File: rtl/fbuf_fill_arbiter.sv
// ----------------------------------------------------------------------------
// fbuf_fill_arbiter
// Shares framebuffer BRAM write port A between single-pixel writes from the
// AXI command path and a rectangle fill engine. Pixel writes always win; the
// fill engine stalls for that cycle and resumes at the same position.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   px_valid/px_addr/px_data    single-pixel write, never back-pressured
//   fill_start                  fill command strobe (ignored while busy)
//   fill_x/y/w/h, fill_color    fill rectangle and value
//   fill_busy                   fill in progress
//   fill_done                   one-cycle completion pulse
//   fill_err                    pulses with fill_done on a rejected command
//   fbuf_en_wr, fbuf_wrea       BRAM enable / write enable (identical)
//   fbuf_addr, fbuf_data        BRAM address / data, zero when idle
// All outputs are registered.
// ----------------------------------------------------------------------------
module fbuf_fill_arbiter
  import fbuf_pkg::*;
#(
  parameter int FRAME_WIDTH     = FRAME_WIDTH_DEF,
  parameter int FRAME_HEIGHT    = FRAME_HEIGHT_DEF,
  parameter int FBUF_ADDR_WIDTH = FBUF_ADDR_WIDTH_DEF,
  parameter int FBUF_DATA_WIDTH = FBUF_DATA_WIDTH_DEF,
  parameter int COORD_WIDTH     = COORD_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       px_valid,
  input  logic [FBUF_ADDR_WIDTH-1:0] px_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] px_data,
  input  logic                       fill_start,
  input  logic [COORD_WIDTH-1:0]     fill_x,
  input  logic [COORD_WIDTH-1:0]     fill_y,
  input  logic [COORD_WIDTH-1:0]     fill_w,
  input  logic [COORD_WIDTH-1:0]     fill_h,
  input  logic [FBUF_DATA_WIDTH-1:0] fill_color,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       fill_err,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);

  localparam int CXW = COORD_WIDTH + 1;
  localparam logic [CXW-1:0] FW_C = CXW'(FRAME_WIDTH);
  localparam logic [CXW-1:0] FH_C = CXW'(FRAME_HEIGHT);

  fill_state_e state, state_next;

  // Latched command
  logic [COORD_WIDTH-1:0]     x_q, y_q, w_q, h_q;
  logic [FBUF_DATA_WIDTH-1:0] color_q;

  logic start_accept, cmd_ok;

  // Walker interface
  logic                       walk_setup, walk_run;
  logic                       walk_valid, walk_last;
  logic [FBUF_ADDR_WIDTH-1:0] walk_addr;

  // Next values of the registered outputs
  logic                       busy_next, done_next, err_next, wr_next;
  logic [FBUF_ADDR_WIDTH-1:0] addr_next;
  logic [FBUF_DATA_WIDTH-1:0] data_next;

  logic                       busy_q, done_q, err_q, wr_q;
  logic [FBUF_ADDR_WIDTH-1:0] addr_q;
  logic [FBUF_DATA_WIDTH-1:0] data_q;

  assign start_accept = (state == IDLE) && fill_start;

  // A command is rejected when its corner lies off-frame or it is empty;
  // oversize rectangles that start on-frame are clipped by the walker.
  assign cmd_ok = ({1'b0, fill_x} < FW_C) && ({1'b0, fill_y} < FH_C) &&
                  (fill_w != '0) && (fill_h != '0);

  // NOTE: the command registers carry no reset; they are written on every
  // accepted start and only read in SETUP/FILL, which always follow one.
  always_ff @(posedge clk) begin
    if (start_accept) begin
      x_q     <= fill_x;
      y_q     <= fill_y;
      w_q     <= fill_w;
      h_q     <= fill_h;
      color_q <= fill_color;
    end
  end

  assign walk_setup = (state == SETUP);
  assign walk_run   = (state == FILL);

  fbuf_rect_walker #(
    .FRAME_WIDTH     (FRAME_WIDTH),
    .FRAME_HEIGHT    (FRAME_HEIGHT),
    .FBUF_ADDR_WIDTH (FBUF_ADDR_WIDTH),
    .COORD_WIDTH     (COORD_WIDTH)
  ) u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .setup (walk_setup),
    .run   (walk_run),
    .stall (px_valid),
    .x     (x_q),
    .y     (y_q),
    .w     (w_q),
    .h     (h_q),
    .addr  (walk_addr),
    .valid (walk_valid),
    .last  (walk_last)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    err_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill_start) begin
          if (cmd_ok) begin
            state_next = SETUP;
          end else begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end
        end
      end
      SETUP: state_next = FILL;
      FILL: begin
        // Finish only on the cycle the last pixel is actually issued.
        if (walk_valid && walk_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next != IDLE);

  // Write-port priority mux: pixel path first, then the fill engine.
  always_comb begin
    wr_next   = 1'b0;
    addr_next = '0;
    data_next = '0;
    if (px_valid) begin
      wr_next   = 1'b1;
      addr_next = px_addr;
      data_next = px_data;
    end else if (walk_valid) begin
      wr_next   = 1'b1;
      addr_next = walk_addr;
      data_next = color_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_next;
      busy_q <= busy_next;
      done_q <= done_next;
      err_q  <= err_next;
      wr_q   <= wr_next;
      addr_q <= addr_next;
      data_q <= data_next;
    end
  end

  assign fill_busy  = busy_q;
  assign fill_done  = done_q;
  assign fill_err   = err_q;
  assign fbuf_en_wr = wr_q;
  assign fbuf_wrea  = wr_q;
  assign fbuf_addr  = addr_q;
  assign fbuf_data  = data_q;

endmodule

// File: tb/tb_fbuf_fill_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fbuf_fill_arbiter
// Self-checking bench for fbuf_fill_arbiter at the default 640x480 geometry.
// A table of per-cycle {inputs, expected next-cycle outputs} records covers
// reset, pixel writes, fills, rejections and clipping; hand-written sequences
// cover pixel collisions, ignored starts and reset in the middle of a fill.
// ----------------------------------------------------------------------------
module tb_fbuf_fill_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          px_valid = 1'b0;
  logic [AW-1:0] px_addr = '0;
  logic [DW-1:0] px_data = '0;
  logic          fill_start = 1'b0;
  logic [CW-1:0] fill_x = '0, fill_y = '0, fill_w = '0, fill_h = '0;
  logic [DW-1:0] fill_color = '0;
  logic          fill_busy, fill_done, fill_err, fbuf_en_wr, fbuf_wrea;
  logic [AW-1:0] fbuf_addr;
  logic [DW-1:0] fbuf_data;

  fbuf_fill_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .px_valid   (px_valid),
    .px_addr    (px_addr),
    .px_data    (px_data),
    .fill_start (fill_start),
    .fill_x     (fill_x),
    .fill_y     (fill_y),
    .fill_w     (fill_w),
    .fill_h     (fill_h),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fill_err   (fill_err),
    .fbuf_en_wr (fbuf_en_wr),
    .fbuf_wrea  (fbuf_wrea),
    .fbuf_addr  (fbuf_addr),
    .fbuf_data  (fbuf_data)
  );

  always #5 clk = ~clk;

  // Output bundle: {busy, done, err, en_wr, wrea, addr, data}
  typedef struct {
    logic          rst_n;
    logic          pv;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic          fs;
    logic [CW-1:0] x, y, w, h;
    logic [DW-1:0] col;
    logic [31:0]   exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] o(int b, int d, int e, int wr, int a, int dt);
    return {b[0], d[0], e[0], wr[0], wr[0], AW'(a), DW'(dt)};
  endfunction

  function automatic logic [31:0] outs();
    return {fill_busy, fill_done, fill_err, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int r, input int pv, input int pa, input int pd, input int fs,
                     input int x, input int y, input int w, input int h, input int col,
                     input logic [31:0] e);
    vec_t v;
    v.rst_n = r[0];  v.pv = pv[0];    v.pa = AW'(pa);   v.pd = DW'(pd);
    v.fs    = fs[0]; v.x  = CW'(x);   v.y  = CW'(y);    v.w  = CW'(w);
    v.h     = CW'(h); v.col = DW'(col); v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic nop(input logic [31:0] e);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endtask

  task automatic pix(input int a, input int d, input logic [31:0] e);
    add(1, 1, a, d, 0, 0, 0, 0, 0, 0, e);
  endtask

  task automatic fil(input int x, input int y, input int w, input int h, input int c,
                     input logic [31:0] e);
    add(1, 0, 0, 0, 1, x, y, w, h, c, e);
  endtask

  task automatic idle_inputs();
    px_valid   = 1'b0;
    px_addr    = '0;
    px_data    = '0;
    fill_start = 1'b0;
  endtask

  task automatic drive_fill(input int x, input int y, input int w, input int h, input int c);
    fill_start = 1'b1;
    fill_x     = CW'(x);
    fill_y     = CW'(y);
    fill_w     = CW'(w);
    fill_h     = CW'(h);
    fill_color = DW'(c);
  endtask

  logic [31:0] z_out, b_out;
  logic [31:0] cexp [1:8];
  int          n_wr, n_done, n_err, done_cyc, first_a, last_a;

  initial begin
    z_out = o(0, 0, 0, 0, 0, 0);
    b_out = o(1, 0, 0, 0, 0, 0);

    // ---------------- table-driven vectors ----------------
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, z_out);          // reset state
    nop(z_out);
    // single pixel
    pix(1234, 'hA5, o(0, 0, 0, 1, 1234, 'hA5));
    nop(z_out);
    // 2x2 fill at (10,5)
    fil(10, 5, 2, 2, 'h3C, b_out);
    nop(b_out);
    nop(o(1, 0, 0, 1, 3210, 'h3C));
    nop(o(1, 0, 0, 1, 3211, 'h3C));
    nop(o(1, 0, 0, 1, 3850, 'h3C));
    nop(o(0, 1, 0, 1, 3851, 'h3C));
    nop(z_out);
    // rejections: w=0, h=0, x off-frame, y off-frame
    fil(3, 3, 0, 2, 'h55, o(0, 1, 1, 0, 0, 0));
    nop(z_out);
    fil(3, 3, 2, 0, 'h55, o(0, 1, 1, 0, 0, 0));
    nop(z_out);
    fil(640, 0, 1, 1, 'h55, o(0, 1, 1, 0, 0, 0));
    nop(z_out);
    fil(0, 480, 1, 1, 'h55, o(0, 1, 1, 0, 0, 0));
    nop(z_out);
    // clipping at bottom-right corner
    fil(638, 479, 4, 3, 'h77, b_out);
    nop(b_out);
    nop(o(1, 0, 0, 1, 307198, 'h77));
    nop(o(0, 1, 0, 1, 307199, 'h77));
    nop(z_out);
    // 1x1 fill at the last column of row 0
    fil(639, 0, 1, 1, 'h09, b_out);
    nop(b_out);
    nop(o(0, 1, 0, 1, 639, 'h09));
    nop(z_out);
    // pixel writes in the start cycle and during SETUP
    add(1, 1, 100, 'h01, 1, 0, 1, 1, 1, 'h22, o(1, 0, 0, 1, 100, 'h01));
    pix(101, 'h02, o(1, 0, 0, 1, 101, 'h02));
    nop(o(0, 1, 0, 1, 640, 'h22));
    nop(z_out);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n      = vecs[i].rst_n;
      px_valid   = vecs[i].pv;
      px_addr    = vecs[i].pa;
      px_data    = vecs[i].pd;
      fill_start = vecs[i].fs;
      fill_x     = vecs[i].x;
      fill_y     = vecs[i].y;
      fill_w     = vecs[i].w;
      fill_h     = vecs[i].h;
      fill_color = vecs[i].col;
      step();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    idle_inputs();
    rst_n = 1'b1;
    step();

    // ---------------- pixel collision during a fill ----------------
    cexp[1] = b_out;
    cexp[2] = b_out;
    cexp[3] = o(1, 0, 0, 1, 3210, 'h3C);
    cexp[4] = o(1, 0, 0, 1, 7, 'hFF);
    cexp[5] = o(1, 0, 0, 1, 3211, 'h3C);
    cexp[6] = o(1, 0, 0, 1, 3850, 'h3C);
    cexp[7] = o(0, 1, 0, 1, 3851, 'h3C);
    cexp[8] = z_out;
    drive_fill(10, 5, 2, 2, 'h3C);
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("collide_c%0d", c), outs(), cexp[c]);
      fill_start = 1'b0;
      px_valid   = (c == 3);
      px_addr    = AW'(7);
      px_data    = 8'hFF;
    end
    idle_inputs();

    // ---------------- start ignored while busy ----------------
    n_wr = 0; n_done = 0; n_err = 0; done_cyc = -1; first_a = -1; last_a = -1;
    drive_fill(0, 10, 3, 2, 'h42);
    for (int c = 1; c <= 40; c++) begin
      step();
      if (fbuf_en_wr) begin
        if (first_a < 0) first_a = int'(fbuf_addr);
        last_a = int'(fbuf_addr);
        n_wr++;
      end
      if (fill_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (fill_err) n_err++;
      if (c == 2) drive_fill(0, 0, 5, 5, 'h99);
      else fill_start = 1'b0;
    end
    check("ign_writes", n_wr, 6);
    check("ign_done_cnt", n_done, 1);
    check("ign_done_cyc", done_cyc, 8);
    check("ign_err", n_err, 0);
    check("ign_first", first_a, 6400);
    check("ign_last", last_a, 7042);
    check("ign_busy", {31'd0, fill_busy}, 0);
    idle_inputs();

    // ---------------- reset in the middle of a fill ----------------
    drive_fill(0, 0, 20, 20, 'h5A);
    for (int c = 1; c <= 10; c++) begin
      step();
      fill_start = 1'b0;
    end
    check("pre_rst_running", {30'd0, fill_busy, fbuf_en_wr}, 3);
    rst_n = 1'b0;
    step();
    check("mid_rst_outs", outs(), z_out);
    rst_n = 1'b1;
    n_wr = 0; n_done = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (fbuf_en_wr) n_wr++;
      if (fill_done || fill_busy) n_done++;
    end
    check("post_rst_writes", n_wr, 0);
    check("post_rst_done_busy", n_done, 0);

    n_wr = 0; n_done = 0; done_cyc = -1; first_a = -1; last_a = -1;
    drive_fill(10, 5, 2, 2, 'h3C);
    for (int c = 1; c <= 20; c++) begin
      step();
      fill_start = 1'b0;
      if (fbuf_en_wr) begin
        if (first_a < 0) first_a = int'(fbuf_addr);
        last_a = int'(fbuf_addr);
        n_wr++;
      end
      if (fill_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    check("refill_writes", n_wr, 4);
    check("refill_done_cyc", done_cyc, 6);
    check("refill_first", first_a, 3210);
    check("refill_last", last_a, 3851);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fbuf_fill_arbiter.md
# fbuf_fill_arbiter

Shares the framebuffer BRAM write port between two requesters:

- **Single-pixel writes:** from the AXI command path.
- **Rectangle fills:** from a built-in fill engine that walks a clipped rectangle in raster order, writing one pixel per cycle.

Pixel writes always win arbitration; the fill engine stalls for that cycle and resumes without losing position. The block sits between the AXI4-Lite command handler and the framebuffer BRAM write port A, replacing the handler's direct connection.

## Interface

Parameters:

- FRAME_WIDTH, 640, pixels per row; row stride for addressing
- FRAME_HEIGHT, 480, rows
- FBUF_ADDR_WIDTH, 19, BRAM address width
- FBUF_DATA_WIDTH, 8, pixel width
- COORD_WIDTH, 12, width of x/y/w/h fields

Ports:

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- px_valid  in  1  single-pixel write request, one pixel per cycle, never back-pressured
- px_addr  in  FBUF_ADDR_WIDTH  pixel address
- px_data  in  FBUF_DATA_WIDTH  pixel value
- fill_start  in  1  fill command strobe, accepted only when fill_busy=0
- fill_x, fill_y  in  COORD_WIDTH  top-left corner
- fill_w, fill_h  in  COORD_WIDTH  rectangle size in pixels
- fill_color  in  FBUF_DATA_WIDTH  fill value
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle completion pulse
- fill_err  out  1  one-cycle pulse with fill_done when command rejected
- fbuf_en_wr, fbuf_wrea  out  1  BRAM enable / write enable, always equal
- fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM address
- fbuf_data  out  FBUF_DATA_WIDTH  BRAM data

## Operation

- **States:** IDLE, SETUP, FILL.
- **IDLE:** on fill_start, latch the command and validate it.
  - Reject if x ≥ FRAME_WIDTH, y ≥ FRAME_HEIGHT, w = 0 or h = 0: stay IDLE; pulse fill_done and fill_err next cycle; no writes.
  - Otherwise go to SETUP.
- **SETUP:** compute the clipped extents and the start row base.
  - x_end = min(x+w, FRAME_WIDTH); y_end = min(y+h, FRAME_HEIGHT).
  - Sums use COORD_WIDTH+1 bits.
  - row_base = y*FRAME_WIDTH. This is the only multiply.
  - Then go to FILL.
- **FILL:** each cycle without px_valid, issue a write at row_base+cx with fill_color.
  - Increment cx.
  - At x_end-1, reset cx to x, add FRAME_WIDTH to row_base, and increment cy.
  - After the write at (x_end-1, y_end-1), return to IDLE.
- **Arbitration:** px_valid=1 always wins.
  - The pixel write is issued and the fill position holds.
  - px_valid in any state, including SETUP, is serviced.
- fill_start while fill_busy=1 is ignored.
- fill_busy = (state ≠ IDLE).

## Timing

- All outputs are registered. Every output resets to 0.
- **Reset mid-fill:** the fill is abandoned, all outputs go to 0, and no fill_done is issued.
- **Pixel path latency:** px_valid at cycle n gives fbuf_en_wr=1 with px_addr/px_data at cycle n+1.
- **Fill sequence:**
  - fill_start at cycle 0.
  - fill_busy=1 from cycle 1.
  - First fill write on the outputs at cycle 3 if unstalled.
  - One pixel per cycle, plus one cycle per px_valid stall.
- **Completion:** fill_done pulses in the same cycle the last fill write appears on the outputs; fill_busy=0 from that cycle.
- **Rejected command:** fill_done=fill_err=1 at cycle 1 only; fill_busy stays 0.
- fbuf_en_wr is deasserted, with addr/data driven to 0, in any cycle with no write.

## Structure

- **Package fbuf_pkg:** FRAME_WIDTH/FRAME_HEIGHT defaults, address/pixel widths, and the fill state enum (IDLE, SETUP, FILL). This package is shared with the command handler.
- **Sub-module fbuf_rect_walker:**
  - Holds the SETUP/FILL counters (cx, cy, row_base).
  - Inputs: stall, latched command. Outputs: addr, valid, last.
- The top level holds validation, the priority mux and the output registers.

## Test plan

- **Single pixel:** px_valid=1, px_addr=1234, px_data=0xA5 at cycle 0 → cycle 1: en/we=1, addr=1234, data=0xA5; cycle 2: all 0.
- **2×2 fill:** fill at (10,5), w=h=2, color 0x3C, start cycle 0 → addrs 3210, 3211, 3850, 3851 at cycles 3–6; fill_done at cycle 6; fill_busy high cycles 1–5.
- **Pixel collision:** same fill, px_valid at cycle 3 with addr 7, data 0xFF → cycle 4 writes addr 7; fill addrs 3210, 3211, 3850, 3851 occur at cycles 3, 5, 6, 7; done at 7.
- **Clipping:** fill at (638,479), w=4, h=3 → exactly addrs 307198, 307199; done with the second write; err=0.
- **Rejection and ignored start:**
  - w=0 → fill_done=fill_err=1 at cycle 1, no writes.
  - A second fill_start during fill_busy is ignored: the write count is unchanged.
- **Reset mid-fill:** rst_n=0 during FILL → next cycle all outputs 0, no fill_done afterwards; a new fill after release runs normally.
